// File: rtl/bite_delay_timer.sv
// Random-delay "fish bite" timer: arms from LFSR bits, counts timebase ticks,
// and emits a one-cycle Expired pulse. The LFSR free-runs only while idle.
module bite_delay_timer #(
    parameter int MIN_DELAY = 1000,
    parameter int RAND_BITS = 12,
    parameter int CNT_W     = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Start,
    input  logic             Cancel,
    input  logic             Tick,
    input  logic [15:0]      RandVal,
    output logic             LfsrRun,
    output logic             Busy,
    output logic             Expired,
    output logic [CNT_W-1:0] Remaining,
    output logic [CNT_W-1:0] Delay,
    output logic [1:0]       fsm_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        FIRE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_DELAY);

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] remaining_n;
    logic [CNT_W-1:0] delay_n;
    logic [CNT_W-1:0] new_delay;

    // Parameter legality guarantees this sum fits in CNT_W bits.
    assign new_delay = MIN_C + CNT_W'(RandVal[RAND_BITS-1:0]);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            Remaining <= '0;
            Delay     <= '0;
        end else begin
            state     <= state_n;
            Remaining <= remaining_n;
            Delay     <= delay_n;
        end
    end

    always_comb begin
        state_n     = state;
        remaining_n = Remaining;
        delay_n     = Delay;
        case (state)
            IDLE: begin
                if (Start && !Cancel) begin
                    delay_n     = new_delay;
                    remaining_n = new_delay;
                    state_n     = COUNT;
                end
            end
            COUNT: begin
                if (Cancel) begin
                    remaining_n = '0;
                    state_n     = IDLE;
                end else if (Tick) begin
                    // A zero count also fires so Remaining can never wrap.
                    if (Remaining <= CNT_W'(1)) begin
                        remaining_n = '0;
                        state_n     = FIRE;
                    end else begin
                        remaining_n = Remaining - CNT_W'(1);
                    end
                end
            end
            FIRE: begin
                state_n = IDLE;
            end
            default: begin
                state_n     = IDLE;
                remaining_n = '0;
            end
        endcase
    end

    assign LfsrRun   = (state == IDLE);
    assign Busy      = (state == COUNT) || (state == FIRE);
    assign Expired   = (state == FIRE);
    assign fsm_state = state;

endmodule

// File: tb/tb_bite_delay_timer.sv
// Directed bench for bite_delay_timer with MIN_DELAY=4, RAND_BITS=3, CNT_W=8.
module tb_bite_delay_timer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        cancel;
    logic        tick;
    logic [15:0] rand_val;
    logic        lfsr_run;
    logic        busy;
    logic        expired;
    logic [7:0]  remaining;
    logic [7:0]  delay;
    logic [1:0]  fsm_state;

    int vectors = 0;
    int errors  = 0;
    logic seen_exp;

    bite_delay_timer #(.MIN_DELAY(4), .RAND_BITS(3), .CNT_W(8)) dut (
        .CLK       (clk),
        .RST       (rst),
        .Start     (start),
        .Cancel    (cancel),
        .Tick      (tick),
        .RandVal   (rand_val),
        .LfsrRun   (lfsr_run),
        .Busy      (busy),
        .Expired   (expired),
        .Remaining (remaining),
        .Delay     (delay),
        .fsm_state (fsm_state)
    );

    always #5 clk = ~clk;

    // Advance one clock; sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // n tick periods (two quiet cycles, then a tick); Expired must stay low meanwhile.
    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b0;
            step();
            if (expired) seen_exp = 1'b1;
            step();
            if (expired) seen_exp = 1'b1;
            tick = 1'b1;
            step();
            tick = 1'b0;
            if (i != n - 1 && expired) seen_exp = 1'b1;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rem"},  remaining, 8'd0);
        check({tag, "_dly"},  delay,     8'd0);
        check({tag, "_busy"}, busy,      1'b0);
        check({tag, "_exp"},  expired,   1'b0);
        check({tag, "_run"},  lfsr_run,  1'b1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; cancel = 1'b0; tick = 1'b0; rand_val = 16'h0000;
        seen_exp = 1'b0;
        step(); step();
        rst = 1'b0;

        // 1: reset/idle values, then D = 4 + 7 = 11
        for (int i = 0; i < 5; i++) begin
            step();
            if (i == 0 || i == 4) check_reset_vals("t1_idle");
        end
        rand_val = 16'hFFFF; start = 1'b1;
        step();
        start = 1'b0;
        check("t1_dly", delay, 8'd11);
        check("t1_rem", remaining, 8'd11);
        check("t1_busy", busy, 1'b1);
        check("t1_run", lfsr_run, 1'b0);
        seen_exp = 1'b0;
        run_ticks(10);
        check("t1_rem10", remaining, 8'd1);
        run_ticks(1);
        check("t1_early_exp", seen_exp, 1'b0);
        check("t1_exp", expired, 1'b1);
        check("t1_rem0", remaining, 8'd0);
        step();
        check("t1_exp_once", expired, 1'b0);
        check("t1_busy_off", busy, 1'b0);
        check("t1_run_on", lfsr_run, 1'b1);

        // 2: D = 4, ticks every cycle including the Start cycle
        rand_val = 16'h0008; start = 1'b1; tick = 1'b1;
        step();
        start = 1'b0;
        check("t2_dly", delay, 8'd4);
        check("t2_rem4", remaining, 8'd4);
        step(); check("t2_rem3", remaining, 8'd3); check("t2_noexp3", expired, 1'b0);
        step(); check("t2_rem2", remaining, 8'd2);
        step(); check("t2_rem1", remaining, 8'd1); check("t2_noexp1", expired, 1'b0);
        step(); check("t2_rem0", remaining, 8'd0); check("t2_exp", expired, 1'b1);
        tick = 1'b0;
        step(); check("t2_idle", busy, 1'b0); check("t2_exp_off", expired, 1'b0);

        // 3: D = 7, cancel with a simultaneous tick at Remaining = 3
        rand_val = 16'h0003; start = 1'b1;
        step();
        start = 1'b0;
        check("t3_dly", delay, 8'd7);
        run_ticks(4);
        check("t3_rem3", remaining, 8'd3);
        cancel = 1'b1; tick = 1'b1;
        step();
        cancel = 1'b0; tick = 1'b0;
        check("t3_busy", busy, 1'b0);
        check("t3_run", lfsr_run, 1'b1);
        check("t3_rem", remaining, 8'd0);
        check("t3_dly_keep", delay, 8'd7);
        check("t3_exp", expired, 1'b0);
        seen_exp = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick = (i % 3 == 2);
            step();
            if (expired) seen_exp = 1'b1;
        end
        tick = 1'b0;
        check("t3_no_exp40", seen_exp, 1'b0);

        // 4: Start+Cancel in IDLE, then Start during COUNT
        rand_val = 16'h0005; start = 1'b1; cancel = 1'b1;
        step();
        start = 1'b0; cancel = 1'b0;
        check("t4_sc_busy", busy, 1'b0);
        check("t4_sc_dly", delay, 8'd7);
        rand_val = 16'h0001; start = 1'b1;
        step();
        start = 1'b0;
        check("t4_dly5", delay, 8'd5);
        seen_exp = 1'b0;
        run_ticks(1);
        check("t4_rem4", remaining, 8'd4);
        rand_val = 16'h0006; start = 1'b1;
        step();
        start = 1'b0;
        check("t4_start_dly", delay, 8'd5);
        check("t4_start_rem", remaining, 8'd4);
        check("t4_start_busy", busy, 1'b1);
        run_ticks(4);
        check("t4_early_exp", seen_exp, 1'b0);
        check("t4_exp", expired, 1'b1);
        step();

        // 5: Start held high, D = 6 then re-latched to 11
        rand_val = 16'h0002; start = 1'b1;
        step();
        check("t5_dly6", delay, 8'd6);
        seen_exp = 1'b0;
        run_ticks(6);
        check("t5_exp1", expired, 1'b1);
        rand_val = 16'h0007;
        step();
        check("t5_fire_idle", busy, 1'b0);
        check("t5_dly_hold", delay, 8'd6);
        step();
        check("t5_rearm_dly", delay, 8'd11);
        check("t5_rearm_rem", remaining, 8'd11);
        run_ticks(11);
        check("t5_early_exp", seen_exp, 1'b0);
        check("t5_exp2", expired, 1'b1);
        start = 1'b0;
        step();
        step();
        check("t5_stay_idle", busy, 1'b0);

        // 6: reset mid-count at Remaining = 5, D = 8
        rand_val = 16'h0004; start = 1'b1;
        step();
        start = 1'b0;
        check("t6_dly", delay, 8'd8);
        run_ticks(3);
        check("t6_rem5", remaining, 8'd5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_vals("t6_rst");
        seen_exp = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick = (i % 3 == 2);
            step();
            if (expired) seen_exp = 1'b1;
        end
        tick = 1'b0;
        check("t6_no_exp", seen_exp, 1'b0);
        check("t6_idle", busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
